// File: rtl/ptc_pkg.sv
// Shared PTC definitions: tap/code widths, lock tracker states and the
// one-hot tap vector to code conversion used by the PTC encoder blocks.
package ptc_pkg;

  localparam int TAP_W  = 16;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              multi_hot;
  } tap_dec_t;

  // Code is the highest set bit among 0..14 plus one; bit 15 is left to the caller.
  function automatic tap_dec_t onehot_to_code(input logic [TAP_W-1:0] taps);
    tap_dec_t res;
    logic     seen;
    res.code      = {CODE_W{1'b0}};
    res.multi_hot = 1'b0;
    seen          = 1'b0;
    for (int i = 0; i < TAP_W - 1; i++) begin
      if (taps[i]) begin
        res.multi_hot = res.multi_hot | seen;
        res.code      = CODE_W'(i + 1);
        seen          = 1'b1;
      end else begin
        res.multi_hot = res.multi_hot;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ptc_lock_tracker.sv
// Consecutive-match lock tracker: walks IDLE -> ACQ -> LOCKED on each
// validated code and drops lock after a run of mismatching/invalid samples.
module ptc_lock_tracker
  import ptc_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic [CODE_W-1:0] code,
  input  logic              err,
  output logic              locked,
  output logic [CODE_W-1:0] locked_code
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  lock_state_e       state_q, state_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic [CODE_W-1:0] ref_code_q, ref_code_d;
  logic [CODE_W-1:0] locked_code_q, locked_code_d;
  logic              locked_q, locked_d;

  // Next-state and counter update, evaluated only on a delivered result
  always_comb begin
    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    ref_code_d    = ref_code_q;
    locked_code_d = locked_code_q;
    locked_d      = locked_q;
    if (vld) begin
      case (state_q)
        IDLE: begin
          if (!err) begin
            state_d     = ACQ;
            match_cnt_d = 4'd1;
            ref_code_d  = code;
          end else begin
            match_cnt_d = 4'd0;
          end
        end
        ACQ: begin
          if (err) begin
            state_d     = IDLE;
            match_cnt_d = 4'd0;
          end else if (code == ref_code_q) begin
            match_cnt_d = sat_inc(match_cnt_q);
            if (sat_inc(match_cnt_q) >= LOCK_C) begin
              state_d       = LOCKED;
              locked_d      = 1'b1;
              locked_code_d = ref_code_q;
              miss_cnt_d    = 4'd0;
            end else begin
              locked_d = 1'b0;
            end
          end else begin
            ref_code_d  = code;
            match_cnt_d = 4'd1;
          end
        end
        LOCKED: begin
          if (!err && (code == locked_code_q)) begin
            miss_cnt_d = 4'd0;
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            if (sat_inc(miss_cnt_q) >= LOSS_C) begin
              // The sample that breaks lock seeds the next acquisition when valid
              locked_d   = 1'b0;
              miss_cnt_d = 4'd0;
              if (!err) begin
                state_d     = ACQ;
                ref_code_d  = code;
                match_cnt_d = 4'd1;
              end else begin
                state_d     = IDLE;
                match_cnt_d = 4'd0;
              end
            end else begin
              locked_d = 1'b1;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Tracker state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      match_cnt_q   <= 4'd0;
      miss_cnt_q    <= 4'd0;
      ref_code_q    <= {CODE_W{1'b0}};
      locked_code_q <= {CODE_W{1'b0}};
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      ref_code_q    <= ref_code_d;
      locked_code_q <= locked_code_d;
      locked_q      <= locked_d;
    end
  end

  assign locked      = locked_q;
  assign locked_code = locked_code_q;

endmodule

// File: rtl/tap_code_encoder.sv
// Two-stage tap vector to code encoder with complement check and lock tracking.
// Optional TAP_CODE_BUBBLE_FIX_EN corrects multi-hot bubbles to the highest tap.
module tap_code_encoder
  import ptc_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [TAP_W-1:0]  taps,
  input  logic [TAP_W-1:0]  taps_b,
  output logic [CODE_W-1:0] code,
  output logic              code_vld,
  output logic              err_onehot,
  output logic              err_compl,
`ifdef TAP_CODE_BUBBLE_FIX_EN
  output logic              bubble_fixed,
`endif
  output logic              locked,
  output logic [CODE_W-1:0] locked_code
);

  logic              s1_vld_q, s1_vld_d;
  logic [TAP_W-1:0]  taps_q, taps_d;
  logic [TAP_W-1:0]  taps_b_q, taps_b_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_vld_q, code_vld_d;
  logic              err_onehot_q, err_onehot_d;
  logic              err_compl_q, err_compl_d;
  tap_dec_t          dec_s;
  logic              oh_bad_s;
  logic              compl_bad_s;
`ifdef TAP_CODE_BUBBLE_FIX_EN
  logic              bubble_fixed_q, bubble_fixed_d;
  logic              fix_s;
`endif

  // Capture stage and validate/encode stage next values
  always_comb begin
    s1_vld_d = sample_en;
    if (sample_en) begin
      taps_d   = taps;
      taps_b_d = taps_b;
    end else begin
      taps_d   = taps_q;
      taps_b_d = taps_b_q;
    end
    dec_s       = onehot_to_code(taps_q);
    compl_bad_s = (taps_b_q != ~taps_q);
`ifdef TAP_CODE_BUBBLE_FIX_EN
    oh_bad_s       = taps_q[TAP_W-1];
    fix_s          = dec_s.multi_hot & ~taps_q[TAP_W-1] & ~compl_bad_s;
    bubble_fixed_d = 1'b0;
`else
    oh_bad_s = taps_q[TAP_W-1] | dec_s.multi_hot;
`endif
    code_vld_d   = s1_vld_q;
    code_d       = code_q;
    err_onehot_d = err_onehot_q;
    err_compl_d  = err_compl_q;
    if (s1_vld_q) begin
      err_onehot_d = oh_bad_s;
      err_compl_d  = compl_bad_s;
`ifdef TAP_CODE_BUBBLE_FIX_EN
      bubble_fixed_d = fix_s;
`endif
      if (!oh_bad_s && !compl_bad_s) begin
        code_d = dec_s.code;
      end else begin
        code_d = code_q;
      end
    end else begin
      code_d = code_q;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      taps_q       <= {TAP_W{1'b0}};
      taps_b_q     <= {TAP_W{1'b0}};
      code_q       <= {CODE_W{1'b0}};
      code_vld_q   <= 1'b0;
      err_onehot_q <= 1'b0;
      err_compl_q  <= 1'b0;
`ifdef TAP_CODE_BUBBLE_FIX_EN
      bubble_fixed_q <= 1'b0;
`endif
    end else begin
      s1_vld_q     <= s1_vld_d;
      taps_q       <= taps_d;
      taps_b_q     <= taps_b_d;
      code_q       <= code_d;
      code_vld_q   <= code_vld_d;
      err_onehot_q <= err_onehot_d;
      err_compl_q  <= err_compl_d;
`ifdef TAP_CODE_BUBBLE_FIX_EN
      bubble_fixed_q <= bubble_fixed_d;
`endif
    end
  end

  ptc_lock_tracker #(
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT)
  ) u_lock (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (code_vld_q),
    .code        (code_q),
    .err         (err_onehot_q | err_compl_q),
    .locked      (locked),
    .locked_code (locked_code)
  );

  assign code       = code_q;
  assign code_vld   = code_vld_q;
  assign err_onehot = err_onehot_q;
  assign err_compl  = err_compl_q;
`ifdef TAP_CODE_BUBBLE_FIX_EN
  assign bubble_fixed = bubble_fixed_q;
`endif

endmodule
